// File: rtl/if_id_stage.sv
// IF/ID pipeline register with the hazard-control FSM that drives PCWrite and Bubble_EX.
// Optional stall-cycle counter output enabled by defining IF_ID_STALL_COUNT_EN.
module if_id_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h00000000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] Instruction_IF,
  input  logic [DATA_WIDTH-1:0] PCPlus4_IF,
  input  logic                  Flush,
  input  logic                  ExtStall,
  input  logic                  MemRead_EX,
  input  logic [4:0]            Rt_EX,
  output logic [DATA_WIDTH-1:0] Instruction_ID,
  output logic [DATA_WIDTH-1:0] PCPlus4_ID,
  output logic                  Valid_ID,
  output logic                  PCWrite,
  output logic                  Bubble_EX
`ifdef IF_ID_STALL_COUNT_EN
  ,
  output logic [31:0]           StallCycles
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    EXT_HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic                  valid_q, valid_d;
  logic                  pend_q, pend_d;
  logic                  pc_write;
  logic                  bubble;
  logic                  lu_hazard;

  assign lu_hazard = MemRead_EX && (Rt_EX != 5'd0) && valid_q &&
                     ((Rt_EX == instr_q[25:21]) || (Rt_EX == instr_q[20:16]));

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    pend_d   = pend_q;
    pc_write = 1'b1;
    bubble   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (ExtStall) begin
          state_d  = EXT_HOLD;
          pc_write = 1'b0;
          if (Flush) pend_d = 1'b1;
        end else if (Flush) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (lu_hazard) begin
          state_d  = LU_STALL;
          pc_write = 1'b0;
          bubble   = 1'b1;
        end else begin
          instr_d = Instruction_IF;
          pc4_d   = PCPlus4_IF;
          valid_d = 1'b1;
        end
      end

      LU_STALL: begin
        if (ExtStall) begin
          state_d  = EXT_HOLD;
          pc_write = 1'b0;
          if (Flush) pend_d = 1'b1;
        end else if (Flush) begin
          state_d = RUN;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else begin
          state_d = RUN;
          instr_d = Instruction_IF;
          pc4_d   = PCPlus4_IF;
          valid_d = 1'b1;
        end
      end

      EXT_HOLD: begin
        if (ExtStall) begin
          pc_write = 1'b0;
          // Any number of flushes during the hold collapse into one squash on release.
          if (Flush) pend_d = 1'b1;
        end else begin
          state_d = RUN;
          pend_d  = 1'b0;
          if (pend_q || Flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end else begin
            instr_d = Instruction_IF;
            pc4_d   = PCPlus4_IF;
            valid_d = 1'b1;
          end
        end
      end

      default: state_d = RUN;
    endcase

    if (Reset) begin
      pc_write = 1'b1;
      bubble   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign Instruction_ID = instr_q;
  assign PCPlus4_ID     = pc4_q;
  assign Valid_ID       = valid_q;
  assign PCWrite        = pc_write;
  assign Bubble_EX      = bubble;

`ifdef IF_ID_STALL_COUNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
    end else if (!pc_write) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign StallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, scoreboard-based bench for if_id_stage: expected IF/ID contents are queued
// when a cycle's stimulus is driven and compared one edge later.
module tb_if_id_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Instruction_IF;
  logic [31:0] PCPlus4_IF;
  logic        Flush;
  logic        ExtStall;
  logic        MemRead_EX;
  logic [4:0]  Rt_EX;
  logic [31:0] Instruction_ID;
  logic [31:0] PCPlus4_ID;
  logic        Valid_ID;
  logic        PCWrite;
  logic        Bubble_EX;
`ifdef IF_ID_STALL_COUNT_EN
  logic [31:0] StallCycles;
  logic [31:0] stall_base;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  if_id_stage dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Instruction_IF(Instruction_IF),
    .PCPlus4_IF    (PCPlus4_IF),
    .Flush         (Flush),
    .ExtStall      (ExtStall),
    .MemRead_EX    (MemRead_EX),
    .Rt_EX         (Rt_EX),
    .Instruction_ID(Instruction_ID),
    .PCPlus4_ID    (PCPlus4_ID),
    .Valid_ID      (Valid_ID),
    .PCWrite       (PCWrite),
    .Bubble_EX     (Bubble_EX)
`ifdef IF_ID_STALL_COUNT_EN
    ,
    .StallCycles   (StallCycles)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // then pop the queued IF/ID expectation after the edge.
  task automatic cycle(input string tag, input logic rst, input logic [31:0] ins,
                       input logic [31:0] pc4, input logic fl, input logic ext,
                       input logic mr, input logic [4:0] rt,
                       input logic exp_pcw, input logic exp_bub,
                       input logic [31:0] exp_ins, input logic [31:0] exp_pc4,
                       input logic exp_val);
    exp_t e;
    Reset          = rst;
    Instruction_IF = ins;
    PCPlus4_IF     = pc4;
    Flush          = fl;
    ExtStall       = ext;
    MemRead_EX     = mr;
    Rt_EX          = rt;
    sb_q.push_back('{instr: exp_ins, pc4: exp_pc4, valid: exp_val});
    @(negedge Clk);
    check({tag, ".PCWrite"}, {31'd0, PCWrite}, {31'd0, exp_pcw});
    check({tag, ".Bubble_EX"}, {31'd0, Bubble_EX}, {31'd0, exp_bub});
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".Instruction_ID"}, Instruction_ID, e.instr);
    check({tag, ".PCPlus4_ID"}, PCPlus4_ID, e.pc4);
    check({tag, ".Valid_ID"}, {31'd0, Valid_ID}, {31'd0, e.valid});
    $display("cycle %-10s rst=%0b ext=%0b fl=%0b mr=%0b rt=%0d | ID=%08h pc4=%08h v=%0b",
             tag, rst, ext, fl, mr, rt, Instruction_ID, PCPlus4_ID, Valid_ID);
  endtask

  initial begin
    Reset = 1'b1; Instruction_IF = '0; PCPlus4_IF = '0; Flush = 1'b0;
    ExtStall = 1'b0; MemRead_EX = 1'b0; Rt_EX = '0;
    @(posedge Clk); #1;

    //          tag         rst ins           pc4    fl ext mr rt   pcw bub exp_ins       exp_pc4 v
    cycle("rst1",      1, 32'h20080005, 32'd4,  0, 0, 0, 5'd0, 1, 0, 32'h00000000, 32'd0,  0);
    cycle("rst2",      1, 32'h20080005, 32'd4,  0, 0, 0, 5'd0, 1, 0, 32'h00000000, 32'd0,  0);
    cycle("first",     0, 32'h20080005, 32'd4,  0, 0, 0, 5'd0, 1, 0, 32'h20080005, 32'd4,  1);
    cycle("ld_add",    0, 32'h01095020, 32'd8,  0, 0, 0, 5'd0, 1, 0, 32'h01095020, 32'd8,  1);
    // Load in EX writes $8, which is rs of the add now in ID.
    cycle("lu_haz",    0, 32'h012A5822, 32'd12, 0, 0, 1, 5'd8, 0, 1, 32'h01095020, 32'd8,  1);
    cycle("lu_rel",    0, 32'h012A5822, 32'd12, 0, 0, 0, 5'd0, 1, 0, 32'h012A5822, 32'd12, 1);
    cycle("ld_rs0",    0, 32'h00094020, 32'd16, 0, 0, 0, 5'd0, 1, 0, 32'h00094020, 32'd16, 1);
    // Rt_EX=0 matches rs=0 but $0 never creates a hazard.
    cycle("lu_rt0",    0, 32'h8C090000, 32'd20, 0, 0, 1, 5'd0, 1, 0, 32'h8C090000, 32'd20, 1);
    cycle("flush",     0, 32'h8C080000, 32'd24, 1, 0, 0, 5'd0, 1, 0, 32'h00000000, 32'd20, 0);
    cycle("post_fl",   0, 32'h20090001, 32'd28, 0, 0, 0, 5'd0, 1, 0, 32'h20090001, 32'd28, 1);
`ifdef IF_ID_STALL_COUNT_EN
    stall_base = StallCycles;
`endif
    cycle("hold1",     0, 32'hAAAA0001, 32'd32, 0, 1, 0, 5'd0, 0, 0, 32'h20090001, 32'd28, 1);
    cycle("hold2_fl",  0, 32'hAAAA0002, 32'd32, 1, 1, 0, 5'd0, 0, 0, 32'h20090001, 32'd28, 1);
    cycle("hold3",     0, 32'hAAAA0003, 32'd32, 0, 1, 0, 5'd0, 0, 0, 32'h20090001, 32'd28, 1);
    cycle("hold_rel",  0, 32'hAAAA0004, 32'd32, 0, 0, 0, 5'd0, 1, 0, 32'h00000000, 32'd28, 0);
`ifdef IF_ID_STALL_COUNT_EN
    check("stall_cnt_delta", StallCycles - stall_base, 32'd3);
`endif
    cycle("resume",    0, 32'h2008000A, 32'd36, 0, 0, 0, 5'd0, 1, 0, 32'h2008000A, 32'd36, 1);
    cycle("hold_fl",   0, 32'hBBBB0001, 32'd40, 1, 1, 0, 5'd0, 0, 0, 32'h2008000A, 32'd36, 1);
    cycle("hold_b",    0, 32'hBBBB0002, 32'd40, 0, 1, 0, 5'd0, 0, 0, 32'h2008000A, 32'd36, 1);
    cycle("rst_hold",  1, 32'hBBBB0003, 32'd40, 0, 1, 0, 5'd0, 1, 0, 32'h00000000, 32'd0,  0);
`ifdef IF_ID_STALL_COUNT_EN
    check("stall_cnt_rst", StallCycles, 32'd0);
`endif
    // No stale squash survives the reset.
    cycle("post_rst",  0, 32'h200B0007, 32'd44, 0, 0, 0, 5'd0, 1, 0, 32'h200B0007, 32'd44, 1);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register for the 5-stage MIPS datapath. Sits directly downstream of the program counter and instruction memory.
- Captures the fetched instruction and PC+4 each cycle.
- Contains the hazard-control FSM that drives PCWrite back to the program counter.
- Handles three events:
  - load-use stalls (one bubble into ID/EX);
  - external multi-cycle stalls;
  - branch/jump flushes, including a flush that arrives during a stall and is deferred.

Parameters:
- DATA_WIDTH, 32, width of instruction and PC values.
- NOP_WORD, 32'h00000000, instruction word loaded on flush/bubble (sll $0,$0,0).

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high.
- Instruction_IF  input  DATA_WIDTH  word from instruction memory for the current PC.
- PCPlus4_IF  input  DATA_WIDTH  PC+4 of the fetched instruction.
- Flush  input  1  branch/jump taken in ID; squash the fetched instruction.
- ExtStall  input  1  external hold request (memory busy); freeze IF/ID and PC.
- MemRead_EX  input  1  instruction in EX is a load.
- Rt_EX  input  5  destination register of the EX-stage load.
- Instruction_ID  output  DATA_WIDTH  registered instruction for decode.
- PCPlus4_ID  output  DATA_WIDTH  registered PC+4 for decode.
- Valid_ID  output  1  1 = Instruction_ID is a real instruction; 0 = bubble.
- PCWrite  output  1  combinational; 0 holds the PC.
- Bubble_EX  output  1  combinational; 1 forces zero control into ID/EX this cycle.

Behaviour:
- Reset values:
  - Instruction_ID = NOP_WORD, PCPlus4_ID = 0, Valid_ID = 0;
  - FSM in RUN; pending-flush flag = 0;
  - PCWrite = 1 and Bubble_EX = 0 while Reset is high.
- Reset mid-stall or mid-flush abandons all state in the same edge.
- Hazard detect (combinational):
  - LU = MemRead_EX & (Rt_EX != 0) & ((Rt_EX == Instruction_ID[25:21]) | (Rt_EX == Instruction_ID[20:16])) & Valid_ID.
- FSM states: RUN, LU_STALL, EXT_HOLD.
  - RUN:
    - ExtStall=1 -> EXT_HOLD; IF/ID holds.
    - else if Flush=1 -> load NOP_WORD, Valid_ID=0; stay RUN.
    - else if LU=1 -> LU_STALL; IF/ID holds.
    - else load Instruction_IF / PCPlus4_IF with Valid_ID=1.
  - LU_STALL: lasts exactly one cycle.
    - Next edge loads IF/ID normally and returns to RUN.
    - If ExtStall=1 instead, goes to EXT_HOLD.
  - EXT_HOLD:
    - IF/ID holds while ExtStall=1.
    - When ExtStall deasserts: if pending-flush is set, load NOP_WORD and clear pending; otherwise load normally. Return to RUN.
- Priority each cycle: Reset > ExtStall > Flush > LU.
- Flush while ExtStall=1 sets the pending-flush flag; it is never dropped.
- Multiple Flush pulses during one hold collapse to a single squash.
- Outputs:
  - PCWrite = 0 whenever IF/ID holds (ExtStall=1, or LU=1 in RUN with no Flush); else 1.
  - Bubble_EX = 1 only in a RUN cycle with LU=1, ExtStall=0, Flush=0.
- Flush overriding LU: the stalled instruction is a branch that cannot resolve under its own stall, so upstream never asserts both. If both are asserted, Flush wins.
- Latency: an instruction presented at edge N appears on Instruction_ID after edge N; zero added latency.
- Bus widths: no arithmetic is performed; PCPlus4 is passed through unmodified.

Optional Feature:
- Macro: IF_ID_STALL_COUNT_EN.
- Defined:
  - adds output StallCycles, 32 bits;
  - increments on every cycle with PCWrite=0 and Reset=0;
  - wraps from 32'hFFFFFFFF to 0;
  - cleared by Reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset=1 for 2 cycles, then stream 0x20080005 / 0x00000004: after the first edge, Instruction_ID=0x20080005, PCPlus4_ID=4, Valid_ID=1, PCWrite=1.
- Load-use hazard:
  - Setup: Instruction_ID=0x01095020 (add $10,$8,$9), MemRead_EX=1, Rt_EX=8.
  - During the hazard cycle: PCWrite=0, Bubble_EX=1, IF/ID unchanged.
  - Next cycle (MemRead_EX=0): new instruction loads, PCWrite=1.
- Load-use with Rt_EX=0 and matching rs=0: no stall; PCWrite=1, Bubble_EX=0.
- Flush=1 with Instruction_IF=0x8C080000: after the edge, Instruction_ID=0x00000000, Valid_ID=0, PCWrite=1.
- Deferred flush:
  - Stimulus: ExtStall=1 for 3 cycles, Flush pulsed in hold cycle 2.
  - During the hold: IF/ID held, PCWrite=0.
  - At the first edge with ExtStall=0: Instruction_ID=NOP, Valid_ID=0.
  - With IF_ID_STALL_COUNT_EN: StallCycles=3.
- Reset asserted during EXT_HOLD with pending flush: all outputs return to reset values. After release, the first fetched instruction loads with Valid_ID=1; no stale squash.
